direction_pulse_gen: RTL and testbench

- Converts four raw push-button/joystick lines (left, right, up, down) into single-cycle x_inc/x_dec/y_inc/y_dec step requests.
- Its outputs drive the cursor-position stage's increment/decrement inputs directly.
- Per input: 2-flop synchroniser and a debounce filter.
- Per axis: a press-and-hold auto-repeat state machine. Each accepted press moves the pixel one step, and a held button keeps stepping at a fixed rate.

---
 rtl/direction_pulse_gen.sv | 188 ++++++++++++++++++
 tb/tb_direction_pulse_gen.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/direction_pulse_gen.sv
// Four raw direction buttons -> synchronised, debounced levels -> per-axis
// press-and-hold auto-repeat FSMs producing one-cycle cursor step pulses.

module dpg_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta, sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module dpg_axis #(
  parameter int REPEAT_DELAY = 10,
  parameter int REPEAT_RATE  = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic repeat_en,
  input  logic inc_lvl,
  input  logic dec_lvl,
  output logic step_inc,
  output logic step_dec
);
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX);
  localparam logic [TW-1:0] DELAY_LD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

  state_t        state, state_nxt;
  // Direction encoded {inc, dec}; both-held collapses to 00 (no movement).
  logic [1:0]    dir, lat, lat_nxt, pulse_nxt;
  logic [TW-1:0] tmr, tmr_nxt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      dir      <= 2'b00;
      lat      <= 2'b00;
      tmr      <= '0;
      step_inc <= 1'b0;
      step_dec <= 1'b0;
    end else begin
      state    <= state_nxt;
      dir      <= {inc_lvl & ~dec_lvl, dec_lvl & ~inc_lvl};
      lat      <= lat_nxt;
      tmr      <= tmr_nxt;
      step_inc <= pulse_nxt[1];
      step_dec <= pulse_nxt[0];
    end
  end

  always_comb begin
    state_nxt = state;
    lat_nxt   = lat;
    tmr_nxt   = tmr;
    pulse_nxt = 2'b00;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (dir != 2'b00) begin
            pulse_nxt = dir;
            lat_nxt   = dir;
            tmr_nxt   = DELAY_LD;
            state_nxt = DELAY;
          end
        end
        DELAY: begin
          if (dir != lat) begin
            state_nxt = IDLE;
          end else if (tmr == '0) begin
            // repeat_en only matters at this decision point
            if (repeat_en) begin
              pulse_nxt = dir;
              tmr_nxt   = RATE_LD;
              state_nxt = REPEAT;
            end else begin
              state_nxt = HOLD;
            end
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        REPEAT: begin
          if (dir != lat) begin
            state_nxt = IDLE;
          end else if (tmr == '0) begin
            pulse_nxt = dir;
            tmr_nxt   = RATE_LD;
          end else begin
            tmr_nxt = tmr - 1'b1;
          end
        end
        HOLD: begin
          if (dir != lat) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end
endmodule

module direction_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_RATE     = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic repeat_en,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic x_inc,
  output logic x_dec,
  output logic y_inc,
  output logic y_dec
);
  localparam int NUM_BTN = 4;

  // Button order: 0 left, 1 right, 2 up, 3 down.
  logic [NUM_BTN-1:0] raw, deb;
  assign raw = {btn_down, btn_up, btn_right, btn_left};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    dpg_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock (clock),
      .reset (reset),
      .raw   (raw[g]),
      .level (deb[g])
    );
  end

  dpg_axis #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_x (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .repeat_en (repeat_en),
    .inc_lvl   (deb[1]),
    .dec_lvl   (deb[0]),
    .step_inc  (x_inc),
    .step_dec  (x_dec)
  );

  dpg_axis #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_y (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .repeat_en (repeat_en),
    .inc_lvl   (deb[3]),
    .dec_lvl   (deb[2]),
    .step_inc  (y_inc),
    .step_dec  (y_dec)
  );
endmodule

// File: tb/tb_direction_pulse_gen.sv
// Bench for direction_pulse_gen: directed scenarios plus random button traffic
// checked against a behavioural model built on press age and run lengths.

module tb_direction_pulse_gen;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 3;

  logic clock, reset, enable, repeat_en;
  logic btn_left, btn_right, btn_up, btn_down;
  logic x_inc, x_dec, y_inc, y_dec;
  logic [3:0] outs, raw_vec;

  assign outs    = {x_inc, x_dec, y_inc, y_dec};
  assign raw_vec = {btn_down, btn_up, btn_right, btn_left};

  int tests = 0;
  int fails = 0;

  direction_pulse_gen #(.DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .repeat_en (repeat_en),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .x_inc     (x_inc),
    .x_dec     (x_dec),
    .y_inc     (y_inc),
    .y_dec     (y_dec)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: levels become debounced after DEB equal synchronised
  // samples; each axis pulses at press age 0, RD, RD+RR, RD+2RR, ...
  bit [3:0] m_s1, m_s2, m_deb, m_last;
  int       m_run [4];
  int       m_dir [2], m_lat [2], m_age [2], m_pulse [2];
  bit       m_act [2], m_stop [2];

  function automatic int dir_of(bit inc, bit dec);
    return (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
  endfunction

  function automatic logic [3:0] exp_o();
    return {m_pulse[0] == 1, m_pulse[0] == -1, m_pulse[1] == 1, m_pulse[1] == -1};
  endfunction

  task automatic model_step();
    if (!reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_last = '0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
      for (int a = 0; a < 2; a++) begin
        m_dir[a] = 0; m_lat[a] = 0; m_age[a] = 0; m_pulse[a] = 0;
        m_act[a] = 0; m_stop[a] = 0;
      end
    end else begin
      for (int a = 0; a < 2; a++) begin
        m_pulse[a] = 0;
        if (!enable) m_act[a] = 0;
        else if (!m_act[a]) begin
          if (m_dir[a] != 0) begin
            m_act[a] = 1; m_lat[a] = m_dir[a]; m_age[a] = 0; m_stop[a] = 0;
            m_pulse[a] = m_dir[a];
          end
        end else if (m_dir[a] != m_lat[a]) m_act[a] = 0;
        else begin
          m_age[a]++;
          if (!m_stop[a]) begin
            if (m_age[a] == RD) begin
              if (repeat_en) m_pulse[a] = m_lat[a];
              else m_stop[a] = 1;
            end else if (m_age[a] > RD && (m_age[a] - RD) % RR == 0) m_pulse[a] = m_lat[a];
          end
        end
      end
      m_dir[0] = dir_of(m_deb[1], m_deb[0]);
      m_dir[1] = dir_of(m_deb[3], m_deb[2]);
      for (int b = 0; b < 4; b++) begin
        if (m_s2[b] == m_last[b]) m_run[b]++;
        else m_run[b] = 1;
        m_last[b] = m_s2[b];
        if (m_run[b] >= DEB && m_s2[b] != m_deb[b]) m_deb[b] = m_s2[b];
      end
      m_s2 = m_s1;
      m_s1 = raw_vec;
    end
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  task automatic settle(int n);
    {btn_left, btn_right, btn_up, btn_down} = 4'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic test_reset();
    int first;
    enable = 1; repeat_en = 1; reset = 0;
    btn_left = 1; btn_up = 1; btn_right = 0; btn_down = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      tests++;
      if (outs !== 4'b0000) begin
        fails++; $display("FAIL reset_outs cyc %0d got %b want 0000", i, outs);
      end
    end
    reset = 1;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      tests++;
      if (outs !== exp_o()) begin
        fails++; $display("FAIL reset_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (x_dec && y_dec && first < 0) first = i;
    end
    tests++;
    if (first != DEB + 3) begin
      fails++; $display("FAIL reset_latency got %0d want %0d", first, DEB + 3);
    end
    settle(20);
  endtask

  task automatic test_clean_press();
    int cnt, first;
    cnt = 0; first = -1;
    for (int i = 0; i < 30; i++) begin
      btn_right = (i < 5);
      @(negedge clock);
      tests++;
      if (outs !== exp_o()) begin
        fails++; $display("FAIL clean_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (x_inc) begin cnt++; if (first < 0) first = i; end
    end
    tests++;
    if (cnt != 1 || first != DEB + 3) begin
      fails++; $display("FAIL clean_press pulses %0d first %0d want 1 at %0d", cnt, first, DEB + 3);
    end
    settle(10);
  endtask

  task automatic test_glitch();
    int hi, lo, seen;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      btn_up = ((i % 4) < 2);
      @(negedge clock);
      tests++;
      if (outs !== exp_o()) begin
        fails++; $display("FAIL glitch_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (y_dec) seen++;
    end
    for (int k = 0; k < 15; k++) begin
      hi = $urandom_range(1, DEB - 1);
      lo = $urandom_range(1, 6);
      for (int j = 0; j < hi + lo; j++) begin
        btn_up = (j < hi);
        @(negedge clock);
        tests++;
        if (outs !== exp_o()) begin
          fails++; $display("FAIL glitch_rand_model got %b want %b", outs, exp_o());
        end
        if (y_dec) seen++;
      end
    end
    tests++;
    if (seen != 0) begin
      fails++; $display("FAIL glitch_reject y_dec pulses %0d want 0", seen);
    end
    settle(10);
  endtask

  task automatic test_auto_repeat();
    int q [$];
    int cnt;
    repeat_en = 1;
    for (int i = 0; i < 50; i++) begin
      btn_down = (i < 40);
      @(negedge clock);
      tests++;
      if (outs !== exp_o()) begin
        fails++; $display("FAIL repeat_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (y_inc) q.push_back(i);
    end
    tests++;
    if (q.size() < 3) begin
      fails++; $display("FAIL repeat_count got %0d want >=3", q.size());
    end else begin
      if (q[0] != DEB + 3 || q[1] != DEB + 3 + RD || q[2] != DEB + 3 + RD + RR) begin
        fails++; $display("FAIL repeat_times got %0d %0d %0d want %0d %0d %0d",
                          q[0], q[1], q[2], DEB + 3, DEB + 3 + RD, DEB + 3 + RD + RR);
      end
      for (int k = 3; k < q.size(); k++) begin
        tests++;
        if (q[k] - q[k-1] != RR) begin
          fails++; $display("FAIL repeat_spacing idx %0d got %0d want %0d", k, q[k] - q[k-1], RR);
        end
      end
    end
    settle(10);
    repeat_en = 0; cnt = 0;
    for (int i = 0; i < 50; i++) begin
      btn_down = (i < 40);
      @(negedge clock);
      tests++;
      if (outs !== exp_o()) begin
        fails++; $display("FAIL norepeat_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (y_inc) cnt++;
    end
    tests++;
    if (cnt != 1) begin
      fails++; $display("FAIL norepeat_count got %0d want 1", cnt);
    end
    repeat_en = 1;
    settle(10);
  endtask

  task automatic test_conflict();
    int first_inc, last_dec;
    first_inc = -1; last_dec = -1;
    for (int i = 0; i < 60; i++) begin
      btn_left  = (i < 40);
      btn_right = (i >= 20);
      @(negedge clock);
      tests++;
      if (outs !== exp_o() || (x_inc && x_dec)) begin
        fails++; $display("FAIL conflict_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (x_inc && first_inc < 0) first_inc = i;
      if (x_dec) last_dec = i;
    end
    tests++;
    if (last_dec > 20 + DEB + 2 || last_dec < DEB + 3 + RD) begin
      fails++; $display("FAIL conflict_stop last x_dec %0d want in [%0d,%0d]", last_dec, DEB + 3 + RD, 20 + DEB + 2);
    end
    tests++;
    if (first_inc != 40 + DEB + 3) begin
      fails++; $display("FAIL reversal_first got %0d want %0d", first_inc, 40 + DEB + 3);
    end
    settle(15);
  endtask

  task automatic test_axes_enable();
    for (int i = 0; i < 60; i++) begin
      btn_right = 1; btn_down = 1;
      enable = !(i >= 22 && i < 27);
      @(negedge clock);
      tests++;
      if (outs !== exp_o() || x_inc !== y_inc) begin
        fails++; $display("FAIL axes_model cyc %0d got %b want %b", i, outs, exp_o());
      end
      if (i >= 22 && i < 27) begin
        tests++;
        if (outs !== 4'b0000) begin
          fails++; $display("FAIL enable_low cyc %0d got %b want 0000", i, outs);
        end
      end
      if (i == 27 || i == 27 + RD) begin
        tests++;
        if (outs !== 4'b1010) begin
          fails++; $display("FAIL enable_return cyc %0d got %b want 1010", i, outs);
        end
      end
    end
    enable = 1;
    settle(15);
  endtask

  task automatic test_random();
    int rem [4];
    bit [3:0] lv;
    lv = '0;
    for (int b = 0; b < 4; b++) rem[b] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (rem[b] == 0) begin
          lv[b] = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
          rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end
        rem[b]--;
      end
      {btn_down, btn_up, btn_right, btn_left} = lv;
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 99) < 2) repeat_en = ~repeat_en;
      reset = ($urandom_range(0, 299) != 0);
      @(negedge clock);
      tests++;
      if (outs !== exp_o() || (x_inc && x_dec) || (y_inc && y_dec)) begin
        fails++; $display("FAIL random_model cyc %0d got %b want %b", i, outs, exp_o());
      end
    end
    reset = 1; enable = 1; repeat_en = 1;
    settle(15);
  endtask

  initial begin
    reset = 0; enable = 0; repeat_en = 0;
    {btn_left, btn_right, btn_up, btn_down} = 4'b0;
    @(negedge clock);
    test_reset();
    test_clean_press();
    test_glitch();
    test_auto_repeat();
    test_conflict();
    test_axes_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
